// File: rtl/aq_axi_sdma64_rd_burst.sv
// AXI4 read master splitting one DMA command into 4 KB-safe INCR bursts and pushing beats into the SDMA64 FIFO.
// Optional build macro AQ_SDMA64_RRESP_CHK_EN: RRESP[1] on a pushed beat sets CMD_ERR and stops further bursts.
module aq_axi_sdma64_rd_burst #(
   parameter int ADRS_WIDTH = 32,
   parameter int LEN_WIDTH  = 24,
   parameter int BURST_MAX  = 16
) (
   input  logic                  FIFO_WR_CLK,
   input  logic                  RST_N,
   input  logic                  CMD_REQ,
   input  logic [ADRS_WIDTH-1:0] CMD_ADRS,
   input  logic [LEN_WIDTH-1:0]  CMD_LEN,
   output logic                  CMD_BUSY,
   output logic                  CMD_DONE,
   output logic                  CMD_ERR,
   output logic [ADRS_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]            M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [63:0]           M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   output logic                  FIFO_WR_ENA,
   output logic [63:0]           FIFO_WR_DATA,
   output logic                  FIFO_WR_LAST,
   input  logic                  FIFO_WR_FULL,
   input  logic                  FIFO_WR_ALM_FULL
);

   localparam int CW = (LEN_WIDTH > 10) ? LEN_WIDTH : 10;
   localparam logic [9:0] BMAX = 10'(BURST_MAX);

   typedef enum logic [2:0] {IDLE, CALC, ARREQ, DATA, DONE} state_t;
   state_t state, state_nxt;

   logic [ADRS_WIDTH-1:0] adrs, adrs_nxt;
   logic [LEN_WIDTH-1:0]  rem, rem_nxt;
   logic [8:0]            blen, blen_c, cnt;
   logic [9:0]            room, lim;
   logic                  arvalid, busy, done;
   logic                  rready, push, last_beat;
   logic                  err, err_hit;
   logic                  unused_ok;

   // Burst length limited by remaining beats, BURST_MAX and distance to the next 4 KB page.
   always_comb begin
      room     = 10'd512 - {1'b0, adrs[11:3]};
      lim      = (room < BMAX) ? room : BMAX;
      blen_c   = (CW'(rem) < CW'(lim)) ? 9'(rem) : 9'(lim);
      rem_nxt  = rem - LEN_WIDTH'(blen);
      adrs_nxt = adrs + ADRS_WIDTH'({blen, 3'b000});
   end

`ifdef AQ_SDMA64_RRESP_CHK_EN
   always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
      if (!RST_N)                       err <= 1'b0;
      else if (state == IDLE && CMD_REQ) err <= 1'b0;
      else if (push && M_AXI_RRESP[1])  err <= 1'b1;
   end
   assign err_hit   = err | (push & M_AXI_RRESP[1]);
   assign unused_ok = ^{M_AXI_RLAST, M_AXI_RRESP[0], CMD_ADRS[2:0]};
`else
   assign err       = 1'b0;
   assign err_hit   = 1'b0;
   assign unused_ok = ^{M_AXI_RLAST, M_AXI_RRESP, CMD_ADRS[2:0]};
`endif

   always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (CMD_REQ) state_nxt = (CMD_LEN == '0) ? DONE : CALC;
         CALC:  state_nxt = ARREQ;
         ARREQ: if (arvalid && M_AXI_ARREADY) state_nxt = DATA;
         DATA:  if (last_beat) state_nxt = (err_hit || rem_nxt == '0) ? DONE : CALC;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rready    = (state == DATA) && !FIFO_WR_FULL;
      push      = M_AXI_RVALID && rready;
      last_beat = push && (cnt == 9'd1);
   end

   always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
      if (!RST_N) begin
         adrs    <= '0;
         rem     <= '0;
         blen    <= '0;
         cnt     <= '0;
         arvalid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= (state == DONE);
         unique case (state)
            IDLE: if (CMD_REQ) begin
               adrs <= {CMD_ADRS[ADRS_WIDTH-1:3], 3'b000};
               rem  <= CMD_LEN;
               busy <= 1'b1;
            end
            CALC: begin
               blen    <= blen_c;
               cnt     <= blen_c;
               arvalid <= !FIFO_WR_ALM_FULL;
            end
            // Once raised, ARVALID only falls on the handshake, whatever ALM_FULL does.
            ARREQ: arvalid <= arvalid ? !M_AXI_ARREADY : !FIFO_WR_ALM_FULL;
            DATA: if (push) begin
               cnt <= cnt - 9'd1;
               if (last_beat) begin
                  adrs <= adrs_nxt;
                  rem  <= rem_nxt;
               end
            end
            DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign M_AXI_ARADDR  = adrs;
   assign M_AXI_ARLEN   = 8'(blen - 9'd1);
   assign M_AXI_ARSIZE  = 3'd3;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARVALID = arvalid;
   assign M_AXI_RREADY  = rready;
   assign FIFO_WR_ENA   = push;
   assign FIFO_WR_DATA  = M_AXI_RDATA;
   assign FIFO_WR_LAST  = last_beat;
   assign CMD_BUSY      = busy;
   assign CMD_DONE      = done;
   assign CMD_ERR       = err;

endmodule

// File: tb/tb_aq_axi_sdma64_rd_burst.sv
// Randomised bench for aq_axi_sdma64_rd_burst: a burst-plan model plus a per-cycle AXI/FIFO checker.
module tb_aq_axi_sdma64_rd_burst;

   localparam int AW = 32;
   localparam int LW = 24;
   localparam int BM = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_req;
   logic [AW-1:0] cmd_adrs;
   logic [LW-1:0] cmd_len;
   logic          cmd_busy, cmd_done, cmd_err;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid, arready;
   logic [63:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast, rvalid, rready;
   logic          wr_ena, wr_last, wr_full, wr_alm_full;
   logic [63:0]   wr_data;

   aq_axi_sdma64_rd_burst #(.ADRS_WIDTH(AW), .LEN_WIDTH(LW), .BURST_MAX(BM)) dut (
      .FIFO_WR_CLK(clk), .RST_N(rst_n),
      .CMD_REQ(cmd_req), .CMD_ADRS(cmd_adrs), .CMD_LEN(cmd_len),
      .CMD_BUSY(cmd_busy), .CMD_DONE(cmd_done), .CMD_ERR(cmd_err),
      .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .FIFO_WR_ENA(wr_ena), .FIFO_WR_DATA(wr_data), .FIFO_WR_LAST(wr_last),
      .FIFO_WR_FULL(wr_full), .FIFO_WR_ALM_FULL(wr_alm_full)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef AQ_SDMA64_RRESP_CHK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic [31:0] plan_a[$];
   int          plan_l[$];
   logic [31:0] seen_a[$];
   int          seen_l[$];
   int          pushes, last_cnt, done_k, first_ar_k;
   logic        err_at_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   // Bursts a command must produce: cut at BURST_MAX and at every 4 KB page end.
   function automatic void build_plan(input logic [31:0] a, input int len);
      logic [31:0] ad;
      int r, room, b;
      plan_a.delete();
      plan_l.delete();
      ad = {a[31:3], 3'b000};
      r  = len;
      while (r > 0) begin
         room = 512 - int'(ad[11:3]);
         b = r;
         if (b > BM)   b = BM;
         if (b > room) b = room;
         plan_a.push_back(ad);
         plan_l.push_back(b);
         ad = ad + 32'(b * 8);
         r  = r - b;
      end
   endfunction

   task automatic drive_idle();
      cmd_req = 0; cmd_adrs = '0; cmd_len = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
      wr_full = 0; wr_alm_full = 0;
   endtask

   // Entered and left at posedge+1; RVALID is left as-is so the reset gating of FIFO_WR_ENA is visible.
   task automatic apply_reset();
      rst_n = 0;
      #1;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_ena", wr_ena, 0);
      chk("rst_last", wr_last, 0);
      chk("rst_busy", cmd_busy, 0);
      chk("rst_done", cmd_done, 0);
      chk("rst_err", cmd_err, 0);
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic run_cmd(input logic [31:0] a, input int len, input int rdy_p, input int vld_p,
                          input int full_p, input int alm_p, input int alm_hold,
                          input int err_beat, input int err_p, input int rst_beat);
      int k, cur_left, earliest, done_cycle;
      bit need_ar, seen_room, err_model, err_vis, exp_arv, exp_rr, exp_ena;
      logic [1:0] rr;
      build_plan(a, len);
      need_ar = plan_a.size() > 0;
      seen_room = 0; err_model = 0; err_vis = 0;
      cur_left = 0; earliest = 2; done_cycle = (len == 0) ? 2 : 1 << 30;
      pushes = 0; last_cnt = 0; done_k = -1; first_ar_k = -1; err_at_done = 0;
      seen_a.delete(); seen_l.delete();
      k = 0;
      forever begin
         cmd_req  = (k == 0) || (cur_left > 0 && pct(10)) || (len == 0 && k == 1);
         cmd_adrs = (k == 0) ? a : $urandom;
         cmd_len  = (k == 0) ? 24'(len) : 24'($urandom_range(1, 50));
         arready  = pct(rdy_p);
         rvalid   = (cur_left > 0) && pct(vld_p);
         rdata    = {$urandom, $urandom};
         rr       = 2'($urandom_range(0, 1));
         if (err_beat == pushes + 1 || pct(err_p)) rr[1] = 1'b1;
         rresp       = rr;
         rlast       = 1'($urandom_range(0, 1));
         wr_full     = pct(full_p);
         wr_alm_full = (k < alm_hold) ? 1'b1 : pct(alm_p);
         @(negedge clk);

         chk("arsize", arsize, 3'd3);
         chk("arburst", arburst, 2'b01);
         chk("busy", cmd_busy, (k >= 1 && k < done_cycle));
         chk("done", cmd_done, (k == done_cycle));
         if (cmd_done) begin done_k = k; err_at_done = cmd_err; end
         if (k >= 1) chk("err", cmd_err, err_vis);

         exp_rr  = (cur_left > 0) && !wr_full;
         exp_ena = exp_rr && rvalid;
         chk("rready", rready, exp_rr);
         chk("wr_ena", wr_ena, exp_ena);
         chk("wr_last", wr_last, exp_ena && cur_left == 1);
         if (exp_ena) begin
            chk("wr_data", wr_data, rdata);
            pushes++;
            if (cur_left == 1) last_cnt++;
            if (ERR_EN && rresp[1]) err_model = 1;
            cur_left--;
            if (cur_left == 0) begin
               if (plan_a.size() == 0 || err_model) begin
                  plan_a.delete(); plan_l.delete();
                  done_cycle = k + 2;
               end else begin
                  need_ar = 1; earliest = k + 2; seen_room = 0;
               end
            end
         end

         exp_arv = need_ar && k >= earliest && seen_room;
         chk("arvalid", arvalid, exp_arv);
         if (arvalid && first_ar_k < 0) first_ar_k = k;
         if (arvalid && need_ar) begin
            chk("araddr", araddr, plan_a[0]);
            chk("arlen", arlen, 8'(plan_l[0] - 1));
            if (arready) begin
               seen_a.push_back(araddr);
               seen_l.push_back(int'(arlen));
               cur_left = plan_l[0];
               void'(plan_a.pop_front());
               void'(plan_l.pop_front());
               need_ar = 0; seen_room = 0;
            end
         end
         if (need_ar && k >= earliest - 1 && !wr_alm_full) seen_room = 1;
         err_vis = err_model;

         if (k == done_cycle) break;
         if (rst_beat > 0 && pushes == rst_beat) begin
            @(posedge clk); #1;
            apply_reset();
            return;
         end
         if (k > 3000) begin
            checks++; errors++;
            $display("FAIL timeout: command at %0h len %0d still busy after %0d cycles", a, len, k);
            @(posedge clk); #1;
            apply_reset();
            return;
         end
         @(posedge clk); #1;
         k++;
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("idle_busy", cmd_busy, 0);
      chk("idle_done", cmd_done, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a;
      drive_idle();
      #1;
      apply_reset();

      // Model pin: page-crossing split.
      build_plan(32'h0000_0FE0, 8);
      chk("plan_n", plan_a.size(), 2);
      chk("plan_a1", plan_a[1], 32'h0000_1000);
      chk("plan_l0", plan_l[0], 4);

      // Streaming case with everything ready.
      run_cmd(32'h0000_1000, 40, 100, 100, 0, 0, 0, 0, 0, 0);
      chk("t1_nbursts", seen_a.size(), 3);
      chk("t1_ar0", {seen_a[0], 32'(seen_l[0])}, {32'h1000, 32'd15});
      chk("t1_ar1", {seen_a[1], 32'(seen_l[1])}, {32'h1080, 32'd15});
      chk("t1_ar2", {seen_a[2], 32'(seen_l[2])}, {32'h1100, 32'd7});
      chk("t1_pushes", pushes, 40);
      chk("t1_lasts", last_cnt, 3);
      chk("t1_first_ar", first_ar_k, 2);

      // 4 KB boundary; low address bits ignored.
      run_cmd(32'h0000_0FE5, 8, 100, 100, 0, 0, 0, 0, 0, 0);
      chk("t2_ar0", {seen_a[0], 32'(seen_l[0])}, {32'h0FE0, 32'd3});
      chk("t2_ar1", {seen_a[1], 32'(seen_l[1])}, {32'h1000, 32'd3});

      // Almost-full held 20 cycles, FULL pulses during the data phase.
      run_cmd(32'h0000_2000, 16, 100, 100, 30, 0, 20, 0, 0, 0);
      chk("t3_first_ar", first_ar_k, 21);
      chk("t3_pushes", pushes, 16);

      // Zero-length command, with a stray request while busy.
      run_cmd(32'h0000_3000, 0, 100, 100, 0, 0, 0, 0, 0, 0);
      chk("t4_done_k", done_k, 2);
      chk("t4_nbursts", seen_a.size(), 0);

      // Reset at beat 5 of a 16-beat burst, then a clean command.
      run_cmd(32'h0000_4000, 16, 100, 100, 0, 0, 0, 0, 0, 5);
      run_cmd(32'h0000_4000, 20, 100, 100, 0, 0, 0, 0, 0, 0);
      chk("t5_pushes", pushes, 20);

`ifdef AQ_SDMA64_RRESP_CHK_EN
      run_cmd(32'h0000_1000, 40, 100, 100, 0, 0, 0, 3, 0, 0);
      chk("t6_nbursts", seen_a.size(), 1);
      chk("t6_pushes", pushes, 16);
      chk("t6_lasts", last_cnt, 1);
      chk("t6_err", err_at_done, 1);
`endif

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if (pct(50)) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
         run_cmd(a, pct(10) ? 0 : $urandom_range(1, 70), $urandom_range(30, 100),
                 $urandom_range(30, 100), $urandom_range(0, 30), $urandom_range(0, 40),
                 0, 0, 3, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
